// File: rtl/traffic_phase_controller.sv
// N-approach traffic signal sequencer: ALL_RED -> GREEN(p) -> YELLOW(p) -> ALL_RED -> GREEN(p+1).
// Define PED_REQUEST_EN to gate the walk light on latched pedestrian requests.
module traffic_phase_controller #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned TIME_W     = 7,
  parameter int unsigned DEF_GREEN  = 30,
  parameter int unsigned DEF_YELLOW = 3,
  parameter int unsigned DEF_ALLRED = 2
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic                                                   tick,
  input  logic                                                   cfg_valid,
  input  logic [$clog2(NUM_PHASES+2)-1:0]                        cfg_sel,
  input  logic [TIME_W-1:0]                                      cfg_time,
  output logic                                                   cfg_ack,
  output logic                                                   cfg_err,
  input  logic [NUM_PHASES-1:0]                                  ped_req,
  output logic [3*NUM_PHASES-1:0]                                road_light,
  output logic [2*NUM_PHASES-1:0]                                ped_light,
  output logic [((NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1)-1:0] active_phase,
  output logic [1:0]                                             state,
  output logic [TIME_W-1:0]                                      time_remaining
);

  localparam int unsigned SelW = $clog2(NUM_PHASES + 2);
  localparam int unsigned PhW  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  typedef enum logic [1:0] {
    StAllRed = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10
  } st_e;

  st_e                     st_q, st_d;
  logic [PhW-1:0]          ph_d, ph_next;
  logic [TIME_W-1:0]       rem_d, green_next, wval;
  logic [TIME_W-1:0]       green_q [NUM_PHASES];
  logic [TIME_W-1:0]       yellow_q, allred_q;
  logic                    enter_green, walk_d, sel_ok;
  logic [3*NUM_PHASES-1:0] road_d;
  logic [2*NUM_PHASES-1:0] ped_d;

  assign state   = st_q;
  assign ph_next = (active_phase == PhW'(NUM_PHASES - 1)) ? '0 : active_phase + 1'b1;
  assign sel_ok  = {{(32 - SelW){1'b0}}, cfg_sel} < 32'(NUM_PHASES + 2);
  assign wval    = (cfg_time == '0) ? TIME_W'(1) : cfg_time;

  always_comb begin
    green_next = green_q[0];
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (ph_next == PhW'(i)) green_next = green_q[i];
    end
  end

  // Count reaching 1 on a tick ends the state, so each state lasts exactly its programmed ticks.
  always_comb begin
    st_d        = st_q;
    ph_d        = active_phase;
    rem_d       = time_remaining;
    enter_green = 1'b0;
    if (tick) begin
      if (time_remaining <= TIME_W'(1)) begin
        unique case (st_q)
          StAllRed: begin
            st_d        = StGreen;
            ph_d        = ph_next;
            rem_d       = green_next;
            enter_green = 1'b1;
          end
          StGreen: begin
            st_d  = StYellow;
            rem_d = yellow_q;
          end
          default: begin
            st_d  = StAllRed;
            rem_d = allred_q;
          end
        endcase
      end else begin
        rem_d = time_remaining - 1'b1;
      end
    end
  end

`ifdef PED_REQUEST_EN
  logic [NUM_PHASES-1:0] req_prev_q, latch_q, latch_d;
  logic                  walk_q;

  // A request rising on the green-entry edge survives the clear and waits for the next green.
  always_comb begin
    walk_d = walk_q & (st_d == StGreen);
    for (int i = 0; i < NUM_PHASES; i++) begin
      latch_d[i] = (latch_q[i] & ~(enter_green && ph_d == PhW'(i))) | (ped_req[i] & ~req_prev_q[i]);
      if (enter_green && ph_d == PhW'(i)) walk_d = latch_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_prev_q <= '0;
      latch_q    <= '0;
      walk_q     <= 1'b0;
    end else begin
      req_prev_q <= ped_req;
      latch_q    <= latch_d;
      walk_q     <= walk_d;
    end
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ^ped_req;
  assign walk_d         = (st_d == StGreen);
`endif

  always_comb begin
    road_d = '0;
    ped_d  = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (ph_d == PhW'(i) && st_d == StGreen)       road_d[3*i +: 3] = 3'b001;
      else if (ph_d == PhW'(i) && st_d == StYellow) road_d[3*i +: 3] = 3'b010;
      else                                          road_d[3*i +: 3] = 3'b100;
      ped_d[2*i +: 2] = (ph_d == PhW'(i) && walk_d) ? 2'b01 : 2'b10;
    end
  end

  // Config writes land after the load above, so a state entered on the same edge sees the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q           <= StAllRed;
      active_phase   <= PhW'(NUM_PHASES - 1);
      time_remaining <= TIME_W'(DEF_ALLRED);
      road_light     <= {NUM_PHASES{3'b100}};
      ped_light      <= {NUM_PHASES{2'b10}};
      cfg_ack        <= 1'b0;
      cfg_err        <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) green_q[i] <= TIME_W'(DEF_GREEN);
      yellow_q       <= TIME_W'(DEF_YELLOW);
      allred_q       <= TIME_W'(DEF_ALLRED);
    end else begin
      st_q           <= st_d;
      active_phase   <= ph_d;
      time_remaining <= rem_d;
      road_light     <= road_d;
      ped_light      <= ped_d;
      cfg_ack        <= cfg_valid & sel_ok;
      cfg_err        <= cfg_valid & ~sel_ok;
      if (cfg_valid && sel_ok) begin
        for (int i = 0; i < NUM_PHASES; i++) begin
          if (cfg_sel == SelW'(i)) green_q[i] <= wval;
        end
        if (cfg_sel == SelW'(NUM_PHASES))     yellow_q <= wval;
        if (cfg_sel == SelW'(NUM_PHASES + 1)) allred_q <= wval;
      end
    end
  end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised N-approach traffic signal sequencer, successor to the fixed two-road principal/secondary controller. Rotates green through NUM_PHASES approaches with per-phase green times, shared yellow and all-red clearance times, optional latched pedestrian requests, and a runtime configuration port driven by the keypad decoder. Sits between the input block (1 Hz tick, keypad data) and the LCD/lamp output block.

## Interface
- NUM_PHASES, 4, number of approaches (2..8)
- TIME_W, 7, width of every time value in seconds
- DEF_GREEN, 30, reset green time for every phase
- DEF_YELLOW, 3, reset yellow time
- DEF_ALLRED, 2, reset all-red clearance time
- clock  in  1  system clock, all flops rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- tick  in  1  one-cycle 1 Hz enable pulse, synchronous to clock
- cfg_valid  in  1  configuration write request
- cfg_sel  in  $clog2(NUM_PHASES+2)  0..NUM_PHASES-1 = green of phase; NUM_PHASES = yellow; NUM_PHASES+1 = all-red
- cfg_time  in  TIME_W  value to write
- cfg_ack  out  1  one-cycle pulse, write accepted
- cfg_err  out  1  one-cycle pulse, cfg_sel out of range, no write
- ped_req  in  NUM_PHASES  pedestrian button per approach, level or pulse
- road_light  out  3*NUM_PHASES  per phase {R,Y,G}: 100 red, 010 yellow, 001 green
- ped_light  out  2*NUM_PHASES  per phase: 10 don't walk, 01 walk
- active_phase  out  max(1,$clog2(NUM_PHASES))  phase owning green/yellow
- state  out  2  00 ALL_RED, 01 GREEN, 10 YELLOW
- time_remaining  out  TIME_W  seconds left in current state

## Operation
- FSM: ALL_RED -> GREEN(p) -> YELLOW(p) -> ALL_RED -> GREEN(p+1)…; p wraps NUM_PHASES-1 -> 0.
- On state entry time_remaining loads the state's time register (green[p], yellow, allred); each tick decrements it; tick with time_remaining==1 transitions instead of decrementing.
- Phase index increments on the ALL_RED -> GREEN transition.
- road_light: active_phase shows G in GREEN, Y in YELLOW; all other phases, and all phases in ALL_RED, show R. Never two non-red phases.
- ped_light: walk only for active_phase during GREEN (subject to Configuration); otherwise don't walk.
- Config: cfg_valid with valid cfg_sel writes register; cfg_time==0 stored as 1. New value applies at next entry of that state; running count unaffected.
- Registers are TIME_W wide; no arithmetic overflow possible (decrement only, floor 1).

## Timing
- Reset values: state ALL_RED, active_phase NUM_PHASES-1 (so first green is phase 0), time_remaining DEF_ALLRED, all road_light red, all ped_light don't walk, cfg_ack/cfg_err 0, green[*]=DEF_GREEN, yellow=DEF_YELLOW, allred=DEF_ALLRED, request latches clear.
- All outputs registered; state, lights, time_remaining update on the edge where tick is sampled.
- cfg_ack or cfg_err asserted the cycle after cfg_valid, for one cycle; back-to-back writes accepted every cycle.
- Simultaneous tick and cfg_valid: both take effect; a write to the register of the state being entered on that edge uses the old value.
- Reset asserted mid-cycle forces all reset values immediately, regardless of clock.
- A state lasts exactly its programmed count of ticks.

## Configuration
- PED_REQUEST_EN defined: rising edge of ped_req[i] sets latch i; walk shown for phase p during GREEN only if latch p was set at GREEN entry; latch p clears on that entry; requests arriving during phase p's own GREEN are held for its next green.
- PED_REQUEST_EN undefined: ped_req ignored, no latches; walk shown for active_phase throughout every GREEN.

## Test plan
- Reset, defaults, NUM_PHASES=4, tick every 10 cycles -> ALL_RED 2 ticks, phase 0 green 30, yellow 3, all-red 2, then phase 1; phase 3 wraps to 0.
- Write cfg_sel=1, cfg_time=5 during phase 0 green -> cfg_ack next cycle; phase 1 green lasts exactly 5 ticks; phase 0 remaining count unchanged.
- cfg_sel=6 (NUM_PHASES=4) -> cfg_err pulse, no register changes; cfg_time=0 to yellow -> yellow lasts 1 tick.
- PED_REQUEST_EN: pulse ped_req[2] during phase 0 -> ped_light[2] walk throughout phase 2 green only; pulse ped_req[2] during phase 2 green -> walk on following phase 2 green, not current.
- Without PED_REQUEST_EN: ped_req all zero -> walk for each active phase in every green.
- Assert reset during YELLOW of phase 1 -> outputs immediately at reset values; after release, sequence restarts with ALL_RED then phase 0.
